// File: rtl/pll_mdrp_seq.sv
// Single-command sequencer for the PLL MDRP port: address/write/read ops, optional
// read-back verify, then lock-loss and relock supervision under a timeout.
module pll_mdrp_seq #(
  parameter int unsigned RD_LAT       = 2,
  parameter int unsigned LOCK_TIMEOUT = 50000,
  parameter int unsigned VERIFY       = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_done,
  output logic [1:0] rsp_err,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic [1:0] mdrp_op,
  output logic       mdrp_inc,
  output logic [7:0] mdrp_wdata,
  input  logic [7:0] mdrp_rdata,
  input  logic       pll_lock
);

  localparam int unsigned TW = 17;
  localparam int unsigned LW = 3;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_ADDR  = 2'b11;

  localparam logic [1:0] ERR_OK     = 2'b00;
  localparam logic [1:0] ERR_VERIFY = 2'b01;
  localparam logic [1:0] ERR_LOSS   = 2'b10;
  localparam logic [1:0] ERR_RELOCK = 2'b11;

  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_SAT   = TW'(LOCK_TIMEOUT);
  localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_WR, S_VADDR, S_RD, S_RWAIT, S_LOCKLOSS, S_RELOCK, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic          is_write, is_write_nxt;
  logic [7:0]    addr_q, addr_nxt;
  logic [7:0]    wdata_q, wdata_nxt;
  logic [LW-1:0] lat_cnt, lat_nxt;
  logic [TW-1:0] to_cnt, to_nxt;
  logic          lock_meta, lock_sync;

  logic          ready_nxt, busy_nxt, done_nxt;
  logic [1:0]    err_nxt, op_nxt;
  logic [7:0]    rdata_nxt, mwdata_nxt;

  assign mdrp_inc = 1'b0;

  // Two-flop resynchronizer for the asynchronous lock indication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_sync <= lock_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      is_write   <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      lat_cnt    <= '0;
      to_cnt     <= '0;
      cmd_ready  <= 1'b0;
      busy       <= 1'b0;
      rsp_done   <= 1'b0;
      rsp_err    <= ERR_OK;
      rsp_rdata  <= 8'h00;
      mdrp_op    <= OP_NOP;
      mdrp_wdata <= 8'h00;
    end else begin
      state      <= state_nxt;
      is_write   <= is_write_nxt;
      addr_q     <= addr_nxt;
      wdata_q    <= wdata_nxt;
      lat_cnt    <= lat_nxt;
      to_cnt     <= to_nxt;
      cmd_ready  <= ready_nxt;
      busy       <= busy_nxt;
      rsp_done   <= done_nxt;
      rsp_err    <= err_nxt;
      rsp_rdata  <= rdata_nxt;
      mdrp_op    <= op_nxt;
      mdrp_wdata <= mwdata_nxt;
    end
  end

  // Next state plus the values the registered outputs take in that state
  always_comb begin
    state_nxt    = state;
    is_write_nxt = is_write;
    addr_nxt     = addr_q;
    wdata_nxt    = wdata_q;
    lat_nxt      = lat_cnt;
    to_nxt       = to_cnt;
    err_nxt      = rsp_err;
    rdata_nxt    = rsp_rdata;
    op_nxt       = OP_NOP;
    mwdata_nxt   = mdrp_wdata;

    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_nxt    = S_ADDR;
          is_write_nxt = cmd_write;
          addr_nxt     = cmd_addr;
          wdata_nxt    = cmd_wdata;
          op_nxt       = OP_ADDR;
          mwdata_nxt   = cmd_addr;
        end
      end
      S_ADDR: begin
        if (is_write) begin
          state_nxt  = S_WR;
          op_nxt     = OP_WRITE;
          mwdata_nxt = wdata_q;
        end else begin
          state_nxt = S_RD;
          op_nxt    = OP_READ;
        end
      end
      S_WR: begin
        if (VERIFY != 0) begin
          state_nxt  = S_VADDR;
          op_nxt     = OP_ADDR;
          mwdata_nxt = addr_q;
        end else begin
          state_nxt = S_LOCKLOSS;
          to_nxt    = '0;
        end
      end
      S_VADDR: begin
        state_nxt = S_RD;
        op_nxt    = OP_READ;
      end
      S_RD: begin
        state_nxt = S_RWAIT;
        lat_nxt   = '0;
      end
      S_RWAIT: begin
        if (lat_cnt == LAT_LAST) begin
          rdata_nxt = mdrp_rdata;
          if (!is_write) begin
            state_nxt = S_DONE;
            err_nxt   = ERR_OK;
          end else if (mdrp_rdata != wdata_q) begin
            state_nxt = S_DONE;
            err_nxt   = ERR_VERIFY;
          end else begin
            state_nxt = S_LOCKLOSS;
            to_nxt    = '0;
          end
        end else begin
          lat_nxt = lat_cnt + LW'(1);
        end
      end
      S_LOCKLOSS: begin
        if (!lock_sync) begin
          state_nxt = S_RELOCK;
          to_nxt    = '0;
        end else if (to_cnt == TO_LAST) begin
          state_nxt = S_DONE;
          err_nxt   = ERR_LOSS;
        end else if (to_cnt != TO_SAT) begin
          to_nxt = to_cnt + TW'(1);
        end
      end
      S_RELOCK: begin
        if (lock_sync) begin
          state_nxt = S_DONE;
          err_nxt   = ERR_OK;
        end else if (to_cnt == TO_LAST) begin
          state_nxt = S_DONE;
          err_nxt   = ERR_RELOCK;
        end else if (to_cnt != TO_SAT) begin
          to_nxt = to_cnt + TW'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    ready_nxt = (state_nxt == S_IDLE);
    busy_nxt  = (state_nxt != S_IDLE);
    done_nxt  = (state_nxt == S_DONE);
  end

endmodule

// File: tb/tb_pll_mdrp_seq.sv
// Directed bench for pll_mdrp_seq: table of single commands against a small PLL
// model, plus hand-written reset-during-write and busy-command sequences.
module tb_pll_mdrp_seq;

  localparam int unsigned RD_LAT       = 2;
  localparam int unsigned LOCK_TIMEOUT = 100;
  localparam int          MAXC         = 400;
  localparam int          NVEC         = 7;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_done;
  logic [1:0] rsp_err;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic [1:0] mdrp_op;
  logic       mdrp_inc;
  logic [7:0] mdrp_wdata;
  logic [7:0] mdrp_rdata = 8'h00;
  logic       pll_lock;

  logic [7:0]  model_data = 8'h00;
  int unsigned pend = 0;

  int n_checks = 0;
  int n_fail   = 0;

  // lock_mode: 0 untouched, 1 drop after edge 8 and restore after edge 28,
  // 2 never drops, 3 dropped before the command and never restored
  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  model;
    int          lock_mode;
    logic [1:0]  err;
    logic [7:0]  rdata;
    int          edges;
    logic [15:0] ops;
    int          nops;
  } vec_t;

  vec_t vecs [NVEC];

  pll_mdrp_seq #(
    .RD_LAT      (RD_LAT),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .VERIFY      (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_done  (rsp_done),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .mdrp_op   (mdrp_op),
    .mdrp_inc  (mdrp_inc),
    .mdrp_wdata(mdrp_wdata),
    .mdrp_rdata(mdrp_rdata),
    .pll_lock  (pll_lock)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // PLL read model: data appears RD_LAT edges after the edge that sees READ
  always @(posedge clk) begin
    if (mdrp_op == 2'b10) begin
      pend       <= RD_LAT;
      mdrp_rdata <= 8'hEE;
    end else if (pend != 0) begin
      pend <= pend - 1;
      if (pend == 1) mdrp_rdata <= model_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
  endtask

  // Issue one command; edge 0 is the acceptance edge
  task automatic run_cmd(input vec_t v, output int edges, output logic [1:0] err,
                         output logic [7:0] rd, output logic [15:0] ops, output int nops);
    edges = -1;
    err   = 2'b00;
    rd    = 8'h00;
    ops   = 16'h0000;
    nops  = 0;
    wait_ready();
    model_data = v.model;
    cmd_write  = v.wr;
    cmd_addr   = v.addr;
    cmd_wdata  = v.wdata;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int n = 0; n < MAXC; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (mdrp_op != 2'b00) begin
        ops = {ops[13:0], mdrp_op};
        nops++;
      end
      if (v.lock_mode == 1 && n == 8)  pll_lock = 1'b0;
      if (v.lock_mode == 1 && n == 28) pll_lock = 1'b1;
      if (rsp_done) begin
        edges = n;
        err   = rsp_err;
        rd    = rsp_rdata;
        break;
      end
    end
  endtask

  initial begin
    int          edges;
    int          nops;
    int          dones;
    logic [1:0]  err;
    logic [7:0]  rd;
    logic [15:0] ops;

    // wr addr wdata model lock err rdata edges ops nops
    vecs[0] = '{1'b0, 8'h12, 8'h00, 8'h5A, 0, 2'b00, 8'h5A,   5, 16'h000E, 2};
    vecs[1] = '{1'b0, 8'hA7, 8'h00, 8'hC3, 0, 2'b00, 8'hC3,   5, 16'h000E, 2};
    vecs[2] = '{1'b1, 8'h08, 8'h3C, 8'h3C, 1, 2'b00, 8'h3C,  31, 16'h00DE, 4};
    vecs[3] = '{1'b1, 8'h08, 8'h3C, 8'h3D, 0, 2'b01, 8'h3D,   7, 16'h00DE, 4};
    vecs[4] = '{1'b1, 8'h55, 8'hAA, 8'hAA, 2, 2'b10, 8'hAA, 107, 16'h00DE, 4};
    vecs[5] = '{1'b1, 8'h5A, 8'h0F, 8'h0F, 3, 2'b11, 8'h0F, 108, 16'h00DE, 4};
    vecs[6] = '{1'b1, 8'hFF, 8'h00, 8'h00, 1, 2'b00, 8'h00,  31, 16'h00DE, 4};

    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 8'h00;
    cmd_wdata = 8'h00;
    pll_lock  = 1'b1;
    #3 rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({cmd_ready, busy, rsp_done, rsp_err, rsp_rdata,
                              mdrp_op, mdrp_inc, mdrp_wdata}), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 32'({cmd_ready, busy}), 32'h2);

    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].lock_mode == 3) begin
        pll_lock = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
      run_cmd(vecs[i], edges, err, rd, ops, nops);
      chk($sformatf("v%0d_latency", i), 32'(edges), 32'(vecs[i].edges));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
      chk($sformatf("v%0d_rdata", i), 32'(rd), 32'(vecs[i].rdata));
      chk($sformatf("v%0d_op_seq", i), 32'(ops), 32'(vecs[i].ops));
      chk($sformatf("v%0d_op_count", i), 32'(nops), 32'(vecs[i].nops));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_width", i), 32'(rsp_done), 32'h0);
      if (vecs[i].lock_mode == 3) begin
        pll_lock = 1'b1;
        repeat (4) @(posedge clk);
        #1;
      end
    end

    // Reset asserted while the WRITE op is on the port
    wait_ready();
    model_data = 8'h3C;
    cmd_write  = 1'b1;
    cmd_addr   = 8'h08;
    cmd_wdata  = 8'h3C;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("seq_addr_phase", 32'({mdrp_op, mdrp_wdata}), 32'h308);
    @(posedge clk);
    #1;
    chk("seq_write_phase", 32'({mdrp_op, mdrp_wdata}), 32'h13C);
    rst_n = 1'b0;
    #1;
    chk("async_reset_op", 32'(mdrp_op), 32'h0);
    chk("async_reset_busy", 32'({busy, cmd_ready}), 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_midreset", 32'(cmd_ready), 32'h1);
    run_cmd(vecs[0], edges, err, rd, ops, nops);
    chk("post_reset_latency", 32'(edges), 32'd5);
    chk("post_reset_rdata", 32'({err, rd}), 32'h05A);

    // cmd_valid pulsed while busy must be dropped
    wait_ready();
    model_data = 8'h66;
    cmd_write  = 1'b0;
    cmd_addr   = 8'h21;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    dones = 0;
    ops   = 16'h0000;
    nops  = 0;
    for (int n = 0; n < 20; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (mdrp_op != 2'b00) begin
        ops = {ops[13:0], mdrp_op};
        nops++;
      end
      if (rsp_done) dones++;
      if (n == 1) begin
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h99;
        cmd_wdata = 8'h11;
      end
      if (n == 3) cmd_valid = 1'b0;
    end
    chk("busy_cmd_done_count", 32'(dones), 32'd1);
    chk("busy_cmd_op_seq", 32'(ops), 32'h000E);
    chk("busy_cmd_op_count", 32'(nops), 32'd2);
    chk("rdata_held", 32'({rsp_err, rsp_rdata}), 32'h066);
    chk("inc_tied_low", 32'(mdrp_inc), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
